// File: rtl/fp_div_pkg.sv
// Shared types, constants and operand classification for the binary32 divider.
package fp_div_pkg;

    localparam int QBITS = 26;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        SPEC,
        DIV,
        ROUND
    } state_t;

    // Denormals are flushed: any zero exponent counts as zero.
    function automatic logic is_zero(input logic [7:0] exp);
        return exp == 8'd0;
    endfunction

    function automatic logic is_inf(input logic [7:0] exp, input logic [22:0] frac);
        return (exp == 8'hFF) && (frac == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [7:0] exp, input logic [22:0] frac);
        return (exp == 8'hFF) && (frac != 23'd0);
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalise, round-to-nearest-even and range-check a raw quotient; purely combinational.
// No state and no flow control: outputs follow inputs in the same cycle.
module fp_div_round
    import fp_div_pkg::*;
(
    input  logic [QBITS-1:0] q,
    input  logic [24:0]      rem,
    input  logic signed [9:0] e,
    input  logic             sign_r,
    output logic [31:0]      res,
    output logic             overflow,
    output logic             underflow
);

    logic signed [9:0] e_n;
    logic signed [9:0] e_f;
    logic [23:0]       mant;
    logic [23:0]       mant_f;
    logic [24:0]       mant_r;
    logic              guard;
    logic              sticky;
    logic              inc;

    always_comb begin
        if (q[QBITS-1]) begin
            mant   = q[25:2];
            guard  = q[1];
            sticky = q[0] | (|rem);
            e_n    = e;
        end else begin
            mant   = q[24:1];
            guard  = q[0];
            sticky = |rem;
            e_n    = e - 10'sd1;
        end

        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, inc};
        mant_f = mant_r[23:0];
        e_f    = e_n;
        // Rounding carried past the hidden bit: renormalise to 1.0 * 2^(e+1).
        if (mant_r[24]) begin
            mant_f = 24'h80_0000;
            e_f    = e_n + 10'sd1;
        end

        overflow  = (e_f >= 10'sd255);
        underflow = (e_f <= 10'sd0);

        if (overflow) begin
            res = {sign_r, INF_MAG};
        end else if (underflow) begin
            res = {sign_r, 31'd0};
        end else begin
            res = {sign_r, e_f[7:0], mant_f[22:0]};
        end
    end

endmodule

// File: rtl/fp_div_core.sv
// Sequential binary32 divider (restoring, 1 bit/cycle); done 28 cycles after accept, 2 for specials.
// start is only accepted while busy is low; requests during an operation are dropped.
module fp_div_core
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [23:0] mantis_a,
    input  logic [23:0] mantis_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    state_t state, state_nxt;

    logic [4:0]        cnt;
    logic [24:0]       rem_r;
    logic [23:0]       dvs_r;
    logic [QBITS-1:0]  q_r;
    logic signed [9:0] e_r;
    logic [7:0]        ea_r, eb_r;
    logic              sa_r, sb_r;

    // Results staged here one cycle before being published with done.
    logic        pend;
    logic [31:0] res_pend;
    logic        inv_pend, dbz_pend, ovf_pend, unf_pend;

    logic              accept;
    logic              spec_hit;
    logic [24:0]       diff;
    logic              qbit;
    logic [24:0]       rem_sub;
    logic [24:0]       rem_nxt;
    logic signed [9:0] e_calc;
    logic              sign_r;

    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [31:0] spec_res;
    logic        spec_inv, spec_dbz;

    logic [31:0] rnd_res;
    logic        rnd_ovf, rnd_unf;

    assign busy   = (state != IDLE) | pend;
    assign accept = start & (state == IDLE) & ~pend;
    assign sign_r = sa_r ^ sb_r;

    assign spec_hit = is_nan(exp_a, mantis_a[22:0]) | is_inf(exp_a, mantis_a[22:0]) | is_zero(exp_a)
                    | is_nan(exp_b, mantis_b[22:0]) | is_inf(exp_b, mantis_b[22:0]) | is_zero(exp_b);

    assign e_calc = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'(BIAS);

    assign diff    = rem_r - {1'b0, dvs_r};
    assign qbit    = (rem_r >= {1'b0, dvs_r});
    assign rem_sub = qbit ? diff : rem_r;
    assign rem_nxt = rem_sub << 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = spec_hit ? SPEC : DIV;
            SPEC:    state_nxt = IDLE;
            DIV:     if (cnt == 5'(QBITS - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Special-case decode works on the captured operands; rem_r still holds mantis_a here.
    always_comb begin
        a_nan  = is_nan(ea_r, rem_r[22:0]);
        a_inf  = is_inf(ea_r, rem_r[22:0]);
        a_zero = is_zero(ea_r);
        b_nan  = is_nan(eb_r, dvs_r[22:0]);
        b_inf  = is_inf(eb_r, dvs_r[22:0]);
        b_zero = is_zero(eb_r);

        spec_res = {sign_r, 31'd0};
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (a_nan | b_nan) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign_r, INF_MAG};
        end else if (b_inf) begin
            spec_res = {sign_r, 31'd0};
        end else if (b_zero) begin
            spec_res = {sign_r, INF_MAG};
            spec_dbz = 1'b1;
        end
    end

    fp_div_round u_round (
        .q         (q_r),
        .rem       (rem_r),
        .e         (e_r),
        .sign_r    (sign_r),
        .res       (rnd_res),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_r       <= '0;
            dvs_r       <= '0;
            q_r         <= '0;
            e_r         <= '0;
            ea_r        <= '0;
            eb_r        <= '0;
            sa_r        <= 1'b0;
            sb_r        <= 1'b0;
            pend        <= 1'b0;
            res_pend    <= '0;
            inv_pend    <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            unf_pend    <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pend) begin
                pend        <= 1'b0;
                done        <= 1'b1;
                result      <= res_pend;
                invalid     <= inv_pend;
                div_by_zero <= dbz_pend;
                overflow    <= ovf_pend;
                underflow   <= unf_pend;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_r <= {1'b0, mantis_a};
                        dvs_r <= mantis_b;
                        q_r   <= '0;
                        cnt   <= '0;
                        e_r   <= e_calc;
                        ea_r  <= exp_a;
                        eb_r  <= exp_b;
                        sa_r  <= sign_a;
                        sb_r  <= sign_b;
                    end
                end
                DIV: begin
                    rem_r <= rem_nxt;
                    q_r   <= {q_r[QBITS-2:0], qbit};
                    cnt   <= cnt + 5'd1;
                end
                ROUND: begin
                    pend     <= 1'b1;
                    res_pend <= rnd_res;
                    inv_pend <= 1'b0;
                    dbz_pend <= 1'b0;
                    ovf_pend <= rnd_ovf;
                    unf_pend <= rnd_unf;
                end
                SPEC: begin
                    pend     <= 1'b1;
                    res_pend <= spec_res;
                    inv_pend <= spec_inv;
                    dbz_pend <= spec_dbz;
                    ovf_pend <= 1'b0;
                    unf_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_div_core.md
Name: fp_div_core

Overview:
- Sequential IEEE-754 single-precision divider core. Computes A / B.
- Sits directly downstream of the operand field-split stage, which supplies sign, 8-bit biased exponent and 24-bit mantissa (hidden bit included) for both operands.
- Produces a packed 32-bit result plus exception flags.
- Mantissa quotient is computed by restoring division, one bit per cycle. Rounding is round-to-nearest-even. Denormals are flushed to zero.

Parameters:
- QBITS, 26, number of quotient bits iterated: 24 significant bits plus guard plus normalisation spare. Fixed for binary32.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- start  in  1  launch request; sampled only when idle.
- sign_a, sign_b  in  1  operand signs.
- exp_a, exp_b  in  8  biased exponents.
- mantis_a, mantis_b  in  24  mantissas with hidden bit in [23].
- busy  out  1  high from the edge that accepts start until the edge that asserts done.
- done  out  1  one-cycle pulse; result and flags are valid in that cycle.
- result  out  32  packed quotient.
- invalid, div_by_zero, overflow, underflow  out  1  each  exception flags, valid with done.

Behaviour:
- Reset (rst_n=0 at an edge) clears state to IDLE and sets busy, done, result and all flags to 0. Reset mid-operation abandons the division; no done pulse is produced.
- Operands are captured at the accepting edge T. Input changes after T have no effect. start is ignored while busy.
- FSM states: IDLE, SPEC, DIV, ROUND.
  - IDLE -> SPEC if start and a special case applies.
  - IDLE -> DIV if start and no special case applies.
  - DIV runs for QBITS edges, then -> ROUND.
  - ROUND -> IDLE.
  - SPEC -> IDLE.
- Latency:
  - Normal path: done is high in the cycle after edge T+28.
  - Special path: done is high in the cycle after edge T+2.
- done is high for exactly 1 cycle. result and flags hold their values until the next done or a reset. Flags not raised by an operation are 0.
- Zero classification: exp==0 means zero regardless of mantissa (FTZ). exp==255 means Inf if mantis[22:0]==0, otherwise NaN. sign_r = sign_a XOR sign_b.
- Special-case priority, highest first:
  1. Either operand NaN -> 0x7FC00000, invalid.
  2. 0/0 or Inf/Inf -> 0x7FC00000, invalid.
  3. Inf/x -> signed Inf.
  4. x/Inf -> signed zero.
  5. Nonzero x/0 -> signed Inf, div_by_zero.
  6. 0/x -> signed zero.
- DIV iteration:
  - Remainder register is 25 bits, initialised to mantis_a. Divisor is mantis_b.
  - Each cycle: if rem >= divisor then rem -= divisor and the quotient bit is 1, else 0. Then rem <<= 1.
  - The result is q[25:0] = floor(Ma * 2^25 / Mb).
- Exponent: e = exp_a - exp_b + BIAS, computed as 10-bit signed.
- Normalisation:
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
  - Otherwise: mantissa = q[24:1], guard = q[0], sticky = (rem != 0), and e -= 1.
- Rounding (RNE): increment the mantissa if guard & (sticky | mantissa[0]). On carry-out (0xFFFFFF -> 0x1000000), set mantissa to 0x800000 and e += 1.
- Range checks, after rounding:
  - e >= 255 -> signed Inf (0x7F800000 | sign), overflow.
  - e <= 0 -> signed zero, underflow.
  - Otherwise pack {sign_r, e[7:0], mantissa[22:0]}.

Decomposition:
- Package fp_div_pkg holds:
  - state enum {IDLE, SPEC, DIV, ROUND};
  - constants QNAN=32'h7FC00000, INF_MAG=31'h7F800000, BIAS, QBITS;
  - classification function is_nan / is_inf / is_zero on (exp, mantis).
- One natural sub-module: fp_div_round. It is purely combinational, takes q, rem, e and sign_r, and outputs the packed result plus overflow/underflow. The FSM and iteration datapath stay in fp_div_core.

Test Plan:
- 6.0/2.0 (A=0x40C00000, B=0x40000000) -> result 0x40400000, no flags, done exactly 28 cycles after the start edge, busy high throughout.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAB (round-up path). 1.0/1.5 (0x3F800000 / 0x3FC00000) -> 0x3F2AAAAB (normalisation e-1 path).
- -1.0/+0 (0xBF800000 / 0x00000000) -> 0xFF800000, div_by_zero, done at T+2. 0/0 -> 0x7FC00000, invalid. NaN 0x7FC00001 / 1.0 -> 0x7FC00000, invalid.
- Max/0.5 (0x7F7FFFFF / 0x3F000000) -> 0x7F800000, overflow. 0x00800000 / 2.0 (0x40000000) -> 0x00000000, underflow.
- start pulsed again at T+5 while busy -> ignored; first result unaffected; exactly one done.
- rst_n low for one cycle at T+10 -> busy=0, done never pulses, result=0. A new start afterwards completes normally with full 28-cycle latency.
